// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART transmitter between the
//               RX echo path (requester 0) and the status/message source
//               (requester 1). Launches each accepted byte with a one-cycle
//               transmit pulse, follows the PHY busy flag through start and
//               completion, abandons bytes whose start never appears, and
//               counts completed bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int START_TIMEOUT = 16,
  parameter int GAP_CYCLES    = 0,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_byte,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_byte,
  output logic             req1_ready,
  output logic             uart_transmit,
  output logic [7:0]       uart_tx_byte,
  input  logic             uart_is_transmitting,
  output logic             busy,
  output logic             grant_id,
  output logic             start_timeout,
  output logic [CNT_W-1:0] tx_count
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LAUNCH     = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_GAP        = 3'd4
  } state_e;

  localparam int          TW       = $clog2(START_TIMEOUT + 1);
  localparam int          GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  // Where a finished or abandoned byte leaves the FSM.
  localparam state_e      S_AFTER  = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             grant_q, grant_d;
  logic             sto_q, sto_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             sel;

  // Arbitration: a lone requester wins outright, contention goes to the one not served last.
  always_comb begin
    sel = req1_valid;
    if (req0_valid && req1_valid) begin
      sel = ~last_grant_q;
    end
    req0_ready = (state_q == S_IDLE) & req0_valid & ~sel;
    req1_ready = (state_q == S_IDLE) & req1_valid & sel;
  end

  // Next-state logic for the launch / start-wait / done-wait / gap sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tx_byte_d    = tx_byte_q;
    grant_d      = grant_q;
    sto_d        = 1'b0;
    cnt_d        = cnt_q;
    to_cnt_d     = to_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          tx_byte_d    = sel ? req1_byte : req0_byte;
          grant_d      = sel;
          last_grant_d = sel;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // The PHY flag is deliberately not looked at here: it may still be
        // high from an earlier byte.
        to_cnt_d = '0;
        state_d  = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (uart_is_transmitting) begin
          state_d = S_WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          // Byte is dropped, never retried and never counted.
          sto_d     = 1'b1;
          gap_cnt_d = '0;
          state_d   = S_AFTER;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!uart_is_transmitting) begin
          cnt_d     = cnt_q + CNT_W'(1);
          gap_cnt_d = '0;
          state_d   = S_AFTER;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to idle at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      tx_byte_q    <= 8'h00;
      grant_q      <= 1'b0;
      sto_q        <= 1'b0;
      cnt_q        <= '0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tx_byte_q    <= tx_byte_d;
      grant_q      <= grant_d;
      sto_q        <= sto_d;
      cnt_q        <= cnt_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // Transmit pulse decoded from state so it falls with an asynchronous reset.
  always_comb begin
    uart_transmit = (state_q == S_LAUNCH);
    busy          = (state_q != S_IDLE);
    uart_tx_byte  = tx_byte_q;
    grant_id      = grant_q;
    start_timeout = sto_q;
    tx_count      = cnt_q;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte requesters. Requester 0 is the RX echo path; requester 1 is the status/message source.
- Round-robin arbitration; accepts one byte at a time; issues a one-cycle transmit pulse to the UART PHY.
- Tracks the PHY is_transmitting flag through start and completion, with a start timeout and a completed-byte counter.
- Sits between the requesters and the uart PHY inside the UART controller.

Parameters:
- START_TIMEOUT, 16, max cycles in WAIT_START for is_transmitting to rise before the byte is abandoned (>=1)
- GAP_CYCLES, 0, idle cycles inserted after each completed byte before the next grant
- CNT_W, 16, width of tx_count

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req0_valid  in  1  requester 0 has a byte
- req0_byte  in  8  requester 0 data; must be stable while req0_valid=1 and not yet accepted
- req0_ready  out  1  requester 0 byte accepted this cycle when req0_valid & req0_ready
- req1_valid  in  1  requester 1 has a byte
- req1_byte  in  8  requester 1 data
- req1_ready  out  1  requester 1 accept
- uart_transmit  out  1  one-cycle start pulse to the PHY
- uart_tx_byte  out  8  registered byte to the PHY, held until the next acceptance
- uart_is_transmitting  in  1  PHY busy flag
- busy  out  1  state != IDLE
- grant_id  out  1  requester of the byte currently or last in flight
- start_timeout  out  1  one-cycle pulse when the start timeout fires
- tx_count  out  CNT_W  completed bytes, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, async) forces these values:
  - state=IDLE; last_grant=1, so req0 wins the first contention
  - uart_transmit=0, uart_tx_byte=8'h00, grant_id=0, start_timeout=0, tx_count=0
  - all internal counters=0
- States: IDLE, LAUNCH, WAIT_START, WAIT_DONE, GAP.
- IDLE:
  - sel = the only valid requester; if both valid, sel = !last_grant.
  - reqK_ready = (state==IDLE) & reqK_valid & (sel==K). This is combinational; at most one ready is high.
  - On acceptance at edge N: uart_tx_byte<=reqK_byte, grant_id<=K, last_grant<=K, state<=LAUNCH.
  - A requester may drop valid before acceptance; arbitration is re-evaluated every cycle.
- LAUNCH:
  - uart_transmit=1 for exactly this one cycle (cycle N+1); state<=WAIT_START; timeout counter cleared.
- WAIT_START:
  - If uart_is_transmitting=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches START_TIMEOUT, pulse start_timeout for one cycle and go to IDLE (or GAP if GAP_CYCLES>0).
  - The abandoned byte is dropped, not retried, and tx_count is not incremented.
- WAIT_DONE:
  - When uart_is_transmitting=0, tx_count<=tx_count+1 (wraps); go to GAP if GAP_CYCLES>0, else IDLE.
  - No timeout in this state.
- GAP: count GAP_CYCLES cycles, then go to IDLE. No ready is asserted during GAP.
- Boundary conditions:
  - is_transmitting already high in LAUNCH (PHY busy from earlier): ignored. WAIT_START samples only from the cycle after LAUNCH.
  - Back-to-back: the next acceptance occurs no earlier than the first IDLE cycle after completion. Minimum byte period = PHY duration + 3 + GAP_CYCLES cycles.
  - Round-robin alternates strictly while both valid. A single requester streams unimpeded.
  - Reset mid-operation: immediate return to reset values; uart_transmit drops asynchronously; the in-flight byte is not counted.
  - tx_count at all-ones + 1 completion -> 0.

Test Plan:
- Single byte: req0_valid=1, byte 8'h77, PHY model busy 10 cycles starting 1 cycle after pulse -> req0_ready high 1 cycle; uart_tx_byte=8'h77; uart_transmit high exactly 1 cycle, the cycle after acceptance; tx_count=1; busy low after completion.
- Contention: req0 and req1 continuously valid (8'hA0, 8'hB1), 4 bytes -> grant order 0,1,0,1; tx_byte sequence A0,B1,A0,B1; tx_count=4; never both ready.
- Start timeout: START_TIMEOUT=8, PHY never asserts busy -> start_timeout pulses once, 8 cycles into WAIT_START; tx_count unchanged; next byte accepted afterwards.
- Gap: GAP_CYCLES=5, req1 streaming -> exactly 5 cycles between the busy-fall completion and the next req1_ready.
- Async reset: assert rst=0 mid WAIT_DONE, off-clock-edge -> outputs reach reset values immediately; after release, req0 wins contention first; tx_count=0.
- Wrap: CNT_W=4, 17 completed bytes -> tx_count reads 1.
